// File: rtl/fifo_rd_ctrl_v2.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_v2
// Read-side pointer and status controller for an async FIFO (rclk domain).
//
// Ports:
//   rclk           read-domain clock
//   rrst_n         synchronous active-low reset
//   rinc           read request from consumer
//   rq2_wptr       write pointer (Gray), already synchronised into rclk
//   underflow_clr  clears the sticky underflow flag
//   rd_en          RAM read strobe (rinc gated by empty), combinational
//   raddr          RAM read address (low bits of binary read pointer)
//   rptr           registered Gray read pointer, to the write-domain sync
//   rempty         registered empty flag
//   ralmost_empty  registered almost-empty flag (level <= AE_THRESH)
//   rlevel         registered fill level, 0..2**ADD_WIDTH
//   runderflow     sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module fifo_rd_ctrl_v2 #(
   parameter int ADD_WIDTH = 3,
   parameter int AE_THRESH = 1
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 rinc,
   input  logic [ADD_WIDTH:0]   rq2_wptr,
   input  logic                 underflow_clr,
   output logic                 rd_en,
   output logic [ADD_WIDTH-1:0] raddr,
   output logic [ADD_WIDTH:0]   rptr,
   output logic                 rempty,
   output logic                 ralmost_empty,
   output logic [ADD_WIDTH:0]   rlevel,
   output logic                 runderflow
);

   localparam logic [ADD_WIDTH:0] LP_AE = (ADD_WIDTH+1)'(AE_THRESH);

   logic [ADD_WIDTH:0] r_bin;
   logic [ADD_WIDTH:0] r_gray;
   logic               r_empty;
   logic               r_aempty;
   logic [ADD_WIDTH:0] r_level;
   logic               r_uflow;

   logic               w_rd_en;
   logic [ADD_WIDTH:0] w_bin_next;
   logic [ADD_WIDTH:0] w_gray_next;
   logic [ADD_WIDTH:0] w_wbin;
   logic [ADD_WIDTH:0] w_level_next;

   // Reads are only honoured when data is known to be present.
   assign w_rd_en     = rinc & ~r_empty;
   assign w_bin_next  = r_bin + {{ADD_WIDTH{1'b0}}, w_rd_en};
   assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   for (genvar g = 0; g <= ADD_WIDTH; g++) begin : g_g2b
      assign w_wbin[g] = ^rq2_wptr[ADD_WIDTH:g];
   end

   // Modulo subtraction; the extra MSB lets a full FIFO read as 2**ADD_WIDTH.
   assign w_level_next = w_wbin - w_bin_next;

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         r_bin    <= '0;
         r_gray   <= '0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_level  <= '0;
         r_uflow  <= 1'b0;
      end else begin
         r_bin    <= w_bin_next;
         r_gray   <= w_gray_next;
         // Compare against the next pointer so empty asserts on the same
         // edge that consumes the last word.
         r_empty  <= (w_gray_next == rq2_wptr);
         r_aempty <= (w_level_next <= LP_AE);
         r_level  <= w_level_next;
         // Set beats clear when both happen together.
         if (rinc && r_empty)
            r_uflow <= 1'b1;
         else if (underflow_clr)
            r_uflow <= 1'b0;
      end
   end

   assign rd_en         = w_rd_en;
   assign raddr         = r_bin[ADD_WIDTH-1:0];
   assign rptr          = r_gray;
   assign rempty        = r_empty;
   assign ralmost_empty = r_aempty;
   assign rlevel        = r_level;
   assign runderflow    = r_uflow;

endmodule

// File: tb/tb_fifo_rd_ctrl_v2.sv
module tb_fifo_rd_ctrl_v2;

   localparam int AW  = 3;
   localparam int AET = 1;
   localparam int PM  = 1 << (AW + 1);   // pointer modulus (16)
   localparam int DEP = 1 << AW;         // depth (8)

   logic          rclk = 1'b0;
   logic          rrst_n;
   logic          rinc;
   logic [AW:0]   rq2_wptr;
   logic          underflow_clr;
   logic          rd_en;
   logic [AW-1:0] raddr;
   logic [AW:0]   rptr;
   logic          rempty;
   logic          ralmost_empty;
   logic [AW:0]   rlevel;
   logic          runderflow;

   fifo_rd_ctrl_v2 #(.ADD_WIDTH(AW), .AE_THRESH(AET)) dut (
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .rinc          (rinc),
      .rq2_wptr      (rq2_wptr),
      .underflow_clr (underflow_clr),
      .rd_en         (rd_en),
      .raddr         (raddr),
      .rptr          (rptr),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rlevel        (rlevel),
      .runderflow    (runderflow)
   );

   always #5 rclk = ~rclk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Behavioural model: counts of words written / read, modulo pointer range.
   int m_wr    = 0;
   int m_rd    = 0;
   bit m_empty = 1'b1;
   bit m_ae    = 1'b1;
   int m_level = 0;
   bit m_uf    = 1'b0;

   function automatic int gray(input int n);
      int b;
      b = n % PM;
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_w(input int n);
      m_wr     = n % PM;
      rq2_wptr = 4'(gray(n));
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   // Model update: what every registered output must hold after this edge.
   always @(posedge rclk) begin
      if (!rrst_n) begin
         m_rd = 0; m_empty = 1; m_ae = 1; m_level = 0; m_uf = 0;
      end else begin
         if (rinc && m_empty)     m_uf = 1;
         else if (underflow_clr)  m_uf = 0;
         if (rinc && !m_empty)    m_rd = (m_rd + 1) % PM;
         m_level = (m_wr - m_rd + PM) % PM;
         m_empty = (m_level == 0);
         m_ae    = (m_level <= AET);
      end
   end

   // Compare process, away from the active edge.
   always @(negedge rclk) begin
      if (chk_en) begin
         chk("rd_en",         int'(rd_en),         int'(rinc && !m_empty));
         chk("raddr",         int'(raddr),         m_rd % DEP);
         chk("rptr",          int'(rptr),          gray(m_rd));
         chk("rempty",        int'(rempty),        int'(m_empty));
         chk("ralmost_empty", int'(ralmost_empty), int'(m_ae));
         chk("rlevel",        int'(rlevel),        m_level);
         chk("runderflow",    int'(runderflow),    int'(m_uf));
         chk("rlevel_max",    int'(rlevel <= DEP), 1);
      end
   end

   logic [AW:0] exp_rptr [5];

   initial begin
      exp_rptr[0] = 4'b0001; exp_rptr[1] = 4'b0011; exp_rptr[2] = 4'b0010;
      exp_rptr[3] = 4'b0110; exp_rptr[4] = 4'b0111;

      // Reset with activity on the inputs
      rrst_n = 1'b0; rinc = 1'b1; underflow_clr = 1'b0; set_w(4);
      tick(); chk_en = 1'b1;
      tick();
      chk("rst_rptr", int'(rptr), 0);
      chk("rst_raddr", int'(raddr), 0);
      chk("rst_rempty", int'(rempty), 1);
      chk("rst_ae", int'(ralmost_empty), 1);
      chk("rst_level", int'(rlevel), 0);
      chk("rst_uf", int'(runderflow), 0);
      rrst_n = 1'b1; rinc = 1'b0;
      #2;
      chk("rel_noedge_empty", int'(rempty), 1);
      chk("rel_noedge_level", int'(rlevel), 0);

      // Fill to 5 then drain
      set_w(5);
      tick();
      chk("fill_level", int'(rlevel), 5);
      chk("fill_empty", int'(rempty), 0);
      chk("fill_ae", int'(ralmost_empty), 0);
      rinc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("drain_level", int'(rlevel), 4 - i);
         chk("drain_raddr", int'(raddr), i + 1);
         chk("drain_rptr", int'(rptr), int'(exp_rptr[i]));
         chk("drain_ae", int'(ralmost_empty), int'((4 - i) <= 1));
         chk("drain_empty", int'(rempty), int'(i == 4));
      end

      // Underflow: read while empty, then simultaneous set/clear, then clear
      chk("uf_rd_en", int'(rd_en), 0);
      tick();
      chk("uf_set", int'(runderflow), 1);
      chk("uf_hold_ptr", int'(raddr), 5);
      underflow_clr = 1'b1;
      tick();
      chk("uf_set_wins", int'(runderflow), 1);
      rinc = 1'b0;
      tick();
      chk("uf_clr", int'(runderflow), 0);
      underflow_clr = 1'b0;

      // Full FIFO from rbin=0
      rrst_n = 1'b0; set_w(0);
      tick();
      rrst_n = 1'b1; set_w(8);
      tick();
      chk("full_level", int'(rlevel), 8);
      chk("full_empty", int'(rempty), 0);
      chk("full_ae", int'(ralmost_empty), 0);
      rinc = 1'b1;
      repeat (8) tick();
      chk("full_drained", int'(rempty), 1);
      chk("full_drained_lvl", int'(rlevel), 0);
      rinc = 1'b0;

      // Mid-operation reset with level 3 and a pending read
      set_w(11);
      tick();
      chk("mid_level", int'(rlevel), 3);
      rinc = 1'b1; rrst_n = 1'b0;
      tick();
      chk("mid_rst_level", int'(rlevel), 0);
      chk("mid_rst_empty", int'(rempty), 1);
      chk("mid_rst_rptr", int'(rptr), 0);
      chk("mid_rst_rd_en", int'(rd_en), 0);
      set_w(0); rrst_n = 1'b1;

      // Randomized streaming, includes many pointer laps
      for (int c = 0; c < 4000; c++) begin
         tick();
         rinc          = ($urandom_range(0, 99) < 55);
         underflow_clr = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 299) == 0) begin
            rrst_n = 1'b0;
            set_w(0);
         end else begin
            rrst_n = 1'b1;
            if (((m_wr - m_rd + PM) % PM) < DEP && ($urandom_range(0, 99) < 50))
               set_w(m_wr + 1);
         end
      end
      tick();
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl_v2.md
Name: fifo_rd_ctrl_v2

Overview:
Read-side pointer and status controller for the async FIFO, in the read clock domain. Successor to the basic read-pointer block, parametrised in depth and almost-empty threshold. Adds:
- a read-enable gated by empty, for the RAM
- a registered Gray pointer for the sync chain
- a fill-level output
- a programmable almost-empty flag
- a sticky underflow flag

It drives the dual-port RAM read address and sends rptr to the write-domain synchroniser.

Parameters:
ADD_WIDTH, 3, RAM address width; FIFO depth = 2**ADD_WIDTH; pointers are ADD_WIDTH+1 bits.
AE_THRESH, 1, almost-empty asserts when fill level <= AE_THRESH; legal range 0..2**ADD_WIDTH.

Ports:
rclk  input  1  read-domain clock; all state updates on its rising edge.
rrst_n  input  1  synchronous active-low reset, sampled on rising edge of rclk.
rinc  input  1  read request from consumer.
rq2_wptr  input  ADD_WIDTH+1  write pointer (Gray), already synchronised into rclk domain.
underflow_clr  input  1  clears the sticky underflow flag.
rd_en  output  1  RAM read strobe, combinational = rinc & ~rempty.
raddr  output  ADD_WIDTH  RAM read address = binary pointer [ADD_WIDTH-1:0].
rptr  output  ADD_WIDTH+1  registered Gray read pointer, to the write-domain synchroniser.
rempty  output  1  registered empty flag.
ralmost_empty  output  1  registered almost-empty flag.
rlevel  output  ADD_WIDTH+1  registered fill level as seen from the read side, 0..2**ADD_WIDTH.
runderflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: on a rising edge of rclk with rrst_n=0, all registers load their reset values; this overrides every other input and also applies mid-operation.
  - rbin=0, rptr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
- Gated increment: rbin_next = rbin + rd_en, modulo 2**(ADD_WIDTH+1). rinc while rempty=1 is ignored: the pointer holds and rd_en=0.
- Gray: rgray_next = rbin_next ^ (rbin_next >> 1). rptr <= rgray_next, so rptr is glitch-free and changes exactly one bit per increment.
- Write pointer decode: wbin = Gray-to-binary of rq2_wptr (XOR prefix from MSB), purely combinational.
- Empty: rempty <= (rgray_next == rq2_wptr). It asserts in the same edge that consumes the last word, so there is no extra latency.
- Level: rlevel <= wbin - rbin_next, modulo 2**(ADD_WIDTH+1). The value is unsigned and pessimistic, because of wptr sync latency.
- Almost-empty: ralmost_empty <= (wbin - rbin_next) <= AE_THRESH.
- Underflow priority, highest first:
  1. rinc & rempty sets runderflow.
  2. Otherwise underflow_clr clears it.
  3. Otherwise it holds.
  - Simultaneous set and clear: set wins.
- Wrap-around: the extra MSB distinguishes laps. The pointer rolls from 2**(ADD_WIDTH+1)-1 to 0 without disturbing rempty or rlevel. raddr wraps every 2**ADD_WIDTH reads.
- Latency:
  - A change on rq2_wptr reaches rempty, rlevel and ralmost_empty after one rclk edge.
  - rinc reaches raddr and rptr after one rclk edge.
  - rd_en has zero latency.
- Read data is taken from the RAM at raddr. The block holds no data and no FSM beyond the pointer and flag registers.
- rq2_wptr is assumed to be valid Gray code. Invalid input is not detected.

Test Plan:
1. Reset (ADD_WIDTH=3, AE_THRESH=1): rrst_n=0 for 2 edges with rinc=1 and rq2_wptr=4'b0110 -> rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0; deassert without an edge -> outputs unchanged until the next edge.
2. Fill then drain: set rq2_wptr = Gray(5) = 4'b0111 -> after 1 edge rempty=0, rlevel=5, ralmost_empty=0. Hold rinc=1 for 5 cycles:
   - rlevel steps 4, 3, 2, 1, 0.
   - ralmost_empty rises when rlevel=1.
   - rempty=1 on the 5th edge.
   - raddr steps 1..5.
   - rptr steps 0001, 0011, 0010, 0110, 0111.
3. Underflow: empty, rinc=1 for 1 cycle -> rd_en=0, pointer holds, runderflow=1. underflow_clr=1 together with rinc=1 while empty -> runderflow stays 1. underflow_clr=1 alone -> runderflow=0 after 1 edge.
4. Wrap-around: write lap of 16 words streamed with reads -> rbin goes 15 to 0, rptr goes 4'b1000 to 4'b0000, raddr wraps at 8. rempty asserts only when the pointers match, and rlevel never exceeds 8.
5. Full FIFO: rq2_wptr=Gray(8)=4'b1100 with rbin=0 -> rlevel=8, rempty=0, ralmost_empty=0. Eight reads bring it back to empty.
6. Mid-operation reset: rrst_n=0 while rlevel=3 and rinc=1 -> next edge all outputs return to reset values, and rd_en is forced to 0 because rempty=1.
